// File: rtl/sram_sp_if.sv
// Bus between the FIFO control logic and its single-port storage array.
interface sram_sp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  ready_o;
    logic                  addr_err_o;

    modport master (
        output addr_i, wdata_i, we_i,
        input  rdata_o, ready_o, addr_err_o
    );

    modport slave (
        input  addr_i, wdata_i, we_i,
        output rdata_o, ready_o, addr_err_o
    );
endinterface

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM, cleared word by word after every reset before
// it accepts traffic; optional output register and read-during-write policy.
module sram_sp #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_WIDTH  = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    parameter int unsigned OUT_REG     = 0,
    parameter int unsigned RD_NEW_DATA = 0
) (
    input  logic           clk,
    input  logic           rst,
    sram_sp_if.slave       bus
);
    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  in_range;

    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                  rd_err_d, rd_err_q;

    assign in_range = (32'(bus.addr_i) < DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.addr_i;
        mem_wdata = bus.wdata_i;
        rd_data_d = '0;
        rd_err_d  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                // Clear sequencer owns the write port; user traffic is ignored.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = bus.we_i && in_range;
                if (!in_range) begin
                    rd_err_d = 1'b1;
                end else if ((RD_NEW_DATA != 0) && bus.we_i) begin
                    rd_data_d = bus.wdata_i;
                end else begin
                    rd_data_d = mem[bus.addr_i];
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // Array itself is never reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_err_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_data_q <= '0;
                out_err_q  <= 1'b0;
            end else begin
                out_data_q <= rd_data_q;
                out_err_q  <= rd_err_q;
            end
        end

        assign bus.rdata_o    = out_data_q;
        assign bus.addr_err_o = out_err_q;
    end else begin : g_no_out_reg
        assign bus.rdata_o    = rd_data_q;
        assign bus.addr_err_o = rd_err_q;
    end

    assign bus.ready_o = (state_q == ST_READY);

endmodule

// File: tb/tb_sram_sp.sv
// Scoreboard bench driving three sram_sp configurations with common stimulus:
// (D16, no out reg, old data), (D16, out reg, new data), (D12, no out reg, old data).
module tb_sram_sp;
    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    sram_sp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if0 ();
    sram_sp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if1 ();
    sram_sp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if2 ();

    assign if0.addr_i = addr;  assign if0.we_i = we;  assign if0.wdata_i = wdata;
    assign if1.addr_i = addr;  assign if1.we_i = we;  assign if1.wdata_i = wdata;
    assign if2.addr_i = addr;  assign if2.we_i = we;  assign if2.wdata_i = wdata;

    sram_sp #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .OUT_REG(0), .RD_NEW_DATA(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    sram_sp #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .OUT_REG(1), .RD_NEW_DATA(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    sram_sp #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4), .OUT_REG(0), .RD_NEW_DATA(0))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [31:0] gd [3];
    logic        ge [3];
    logic        gr [3];
    assign gd[0] = if0.rdata_o;  assign ge[0] = if0.addr_err_o;  assign gr[0] = if0.ready_o;
    assign gd[1] = if1.rdata_o;  assign ge[1] = if1.addr_err_o;  assign gr[1] = if1.ready_o;
    assign gd[2] = if2.rdata_o;  assign ge[2] = if2.addr_err_o;  assign gr[2] = if2.ready_o;

    // Reference state per instance
    logic [31:0] mm [3][16];
    logic        rdy [3];
    int unsigned cnt [3];
    exp_t q0[$], q1[$], q2[$];

    function automatic int unsigned dep(input int unsigned k);
        return (k == 2) ? 12 : 16;
    endfunction

    function automatic int unsigned lat(input int unsigned k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic rnew(input int unsigned k);
        return (k == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input int unsigned k, input exp_t x);
        case (k)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    function automatic int unsigned sb_size(input int unsigned k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_pop(input int unsigned k, output exp_t x);
        case (k)
            0: x = q0.pop_front();
            1: x = q1.pop_front();
            default: x = q2.pop_front();
        endcase
    endtask

    task automatic sb_flush();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic step(input logic r, input logic [3:0] a, input logic w, input logic [31:0] wd);
        exp_t x;
        rst   = r;
        addr  = a;
        we    = w;
        wdata = wd;
        for (int unsigned k = 0; k < 3; k++) begin
            x.d = '0;
            x.e = 1'b0;
            if (!r && rdy[k]) begin
                if (32'(a) >= dep(k))   x.e = 1'b1;
                else if (w && rnew(k))  x.d = wd;
                else                    x.d = mm[k][a];
            end
            if (!r) sb_push(k, x);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            if (r) begin
                rdy[k] = 1'b0;
                cnt[k] = 0;
            end else if (!rdy[k]) begin
                mm[k][cnt[k]] = '0;
                cnt[k]++;
                if (cnt[k] == dep(k)) rdy[k] = 1'b1;
            end else if (w && (32'(a) < dep(k))) begin
                mm[k][a] = wd;
            end
        end
        @(posedge clk);
        #1;
        if (r) sb_flush();
        for (int unsigned k = 0; k < 3; k++) begin
            check($sformatf("ready%0d", k), 32'(gr[k]), 32'(rdy[k]));
            if (r) begin
                check($sformatf("rst_rdata%0d", k), gd[k], 32'h0);
                check($sformatf("rst_err%0d", k), 32'(ge[k]), 32'h0);
            end else if (sb_size(k) == lat(k)) begin
                sb_pop(k, x);
                check($sformatf("rdata%0d_a%0d", k, a), gd[k], x.d);
                check($sformatf("err%0d_a%0d", k, a), 32'(ge[k]), 32'(x.e));
            end
        end
    endtask

    initial begin
        for (int unsigned k = 0; k < 3; k++) begin
            rdy[k] = 1'b0;
            cnt[k] = 0;
            for (int unsigned j = 0; j < 16; j++) mm[k][j] = 'x;
        end

        // Reset, then clear sequence with a write held asserted throughout
        step(1'b1, 4'd0, 1'b1, 32'hDEADBEEF);
        step(1'b1, 4'd0, 1'b1, 32'hDEADBEEF);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b1, 32'hDEADBEEF);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 32'h0);

        // Write pattern, read back
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b1, 32'hA5A50000 + i);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 32'h0);

        // Read-during-write on address 3
        step(1'b0, 4'd3, 1'b1, 32'h11111111);
        step(1'b0, 4'd3, 1'b1, 32'h22222222);
        step(1'b0, 4'd3, 1'b0, 32'h0);

        // Single write/read then streaming reads
        step(1'b0, 4'd7, 1'b1, 32'h12345678);
        step(1'b0, 4'd7, 1'b0, 32'h0);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 32'h0);

        // Out-of-range write/read (only out of range for the DEPTH=12 instance)
        step(1'b0, 4'd13, 1'b1, 32'hFFFFFFFF);
        step(1'b0, 4'd13, 1'b0, 32'h0);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 32'h0);

        // Fill, then reset in the middle of a write burst
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b1, 32'hCAFEF00D);
        for (int unsigned i = 0; i < 6; i++) step(1'b0, 4'(i), 1'b1, 32'hBEEF0000 + i);
        step(1'b1, 4'd6, 1'b1, 32'hBEEF0006);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b1, 32'hCAFEF00D);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 32'h0);

        // Random mixed traffic
        for (int unsigned i = 0; i < 60; i++)
            step(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
        for (int unsigned i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 32'h0);
        step(1'b0, 4'd0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
